// File: rtl/conv_kxk_acc_pipe.sv
// KxK convolution MAC: one window x weights per beat, CIN beats accumulated per
// output pixel, then floor-shift requantisation, saturation and optional ReLU.

module conv_kxk_acc_pipe_mul #(
  parameter int DW = 8,
  parameter int WW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [WW-1:0] b,
  output logic [DW+WW-1:0]     p
);
  localparam int PW = DW + WW;

  logic signed [PW-1:0] ax, bx;
  assign ax = PW'(a);
  assign bx = PW'(b);

  always_ff @(posedge clk) begin
    if (rst)     p <= '0;
    else if (en) p <= ax * bx;
  end
endmodule

module conv_kxk_acc_pipe #(
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int K     = 3,
  parameter int CIN   = 4,
  parameter int SHIFT = 8,
  parameter int OW    = 8,
  parameter int ACC_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              relu_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K*K*DW-1:0] in_data,
  input  logic [K*K*WW-1:0] in_weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OW-1:0]     out_data,
  output logic              out_sat,
  output logic              busy
);
  localparam int N    = K * K;
  localparam int PW   = DW + WW;
  localparam int CW   = (CIN > 1) ? $clog2(CIN) : 1;
  localparam int QMXI = 2**(OW-1) - 1;
  localparam int QMNI = -(2**(OW-1));
  localparam logic [CW-1:0]           LAST = CW'(CIN - 1);
  localparam logic signed [ACC_W-1:0] QMAX = ACC_W'(QMXI);
  localparam logic signed [ACC_W-1:0] QMIN = ACC_W'(QMNI);

  typedef struct packed {
    logic first;
    logic last;
    logic relu;
  } s1_ctl_t;

  logic                    stall, accept;
  logic [1:0]              vld_pipe;   // [0] S1 holds a beat, [1] output register valid
  logic [CW-1:0]           ch_cnt;
  logic                    relu_grp;
  s1_ctl_t                 s1;
  logic [N-1:0][PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc, tree, acc_next, q;
  logic signed [OW-1:0]    qc, res;
  logic                    sat;

  assign stall     = vld_pipe[1] & ~out_ready;
  assign in_ready  = ~stall & ~rst;
  assign accept    = in_valid & in_ready;
  assign out_valid = vld_pipe[1];
  assign busy      = (ch_cnt != '0) | vld_pipe[0] | vld_pipe[1];

  for (genvar i = 0; i < N; i++) begin : g_lane
    conv_kxk_acc_pipe_mul #(.DW(DW), .WW(WW)) u_mul (
      .clk (clk),
      .rst (rst),
      .en  (accept),
      .a   (in_data[i*DW +: DW]),
      .b   (in_weight[i*WW +: WW]),
      .p   (prod[i])
    );
  end

  always_comb begin
    tree = '0;
    for (int i = 0; i < N; i++) tree = tree + ACC_W'($signed(prod[i]));
    acc_next = s1.first ? tree : acc + tree;
    q   = acc_next >>> SHIFT;
    sat = 1'b0;
    qc  = q[OW-1:0];
    if (q > QMAX) begin
      qc  = QMAX[OW-1:0];
      sat = 1'b1;
    end else if (q < QMIN) begin
      qc  = QMIN[OW-1:0];
      sat = 1'b1;
    end
    res = (s1.relu && qc[OW-1]) ? '0 : qc;
  end

  // Whole pipeline freezes while a result waits; otherwise the output slot is
  // either empty or being drained this edge, so it can simply be overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      ch_cnt   <= '0;
      relu_grp <= 1'b0;
      s1       <= '0;
      acc      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (!stall) begin
      vld_pipe[0] <= accept;
      if (accept) begin
        s1.first <= (ch_cnt == '0);
        s1.last  <= (ch_cnt == LAST);
        s1.relu  <= (ch_cnt == '0) ? relu_en : relu_grp;
        if (ch_cnt == '0) relu_grp <= relu_en;
        ch_cnt <= (ch_cnt == LAST) ? '0 : ch_cnt + 1'b1;
      end
      if (vld_pipe[0]) acc <= acc_next;
      if (vld_pipe[0] && s1.last) begin
        vld_pipe[1] <= 1'b1;
        out_data    <= res;
        out_sat     <= sat;
      end else begin
        vld_pipe[1] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_kxk_acc_pipe.sv
// Directed bench: a CIN=1 instance for latency/saturation/floor/back-to-back and a
// CIN=4 instance for accumulation, backpressure, ReLU capture and mid-group reset.

module tb_conv_kxk_acc_pipe;
  localparam int DW = 8, WW = 8, K = 3, N = K*K, OW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic a_relu_en = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b1;
  logic a_in_ready, a_out_valid, a_out_sat, a_busy;
  logic [N*DW-1:0] a_in_data = '0;
  logic [N*WW-1:0] a_in_weight = '0;
  logic [OW-1:0]   a_out_data;

  logic b_relu_en = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic b_in_ready, b_out_valid, b_out_sat, b_busy;
  logic [N*DW-1:0] b_in_data = '0;
  logic [N*WW-1:0] b_in_weight = '0;
  logic [OW-1:0]   b_out_data;

  int n_chk = 0;
  int n_err = 0;
  logic [OW:0] got_q[$];

  always #5 clk = ~clk;

  conv_kxk_acc_pipe #(.DW(DW), .WW(WW), .K(K), .CIN(1), .SHIFT(8), .OW(OW), .ACC_W(24)) u_dut1 (
    .clk(clk), .rst(rst), .relu_en(a_relu_en), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_weight(a_in_weight), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_sat(a_out_sat), .busy(a_busy)
  );

  conv_kxk_acc_pipe #(.DW(DW), .WW(WW), .K(K), .CIN(4), .SHIFT(8), .OW(OW), .ACC_W(24)) u_dut4 (
    .clk(clk), .rst(rst), .relu_en(b_relu_en), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_weight(b_in_weight), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_sat(b_out_sat), .busy(b_busy)
  );

  always @(posedge clk)
    if (!rst && b_out_valid && b_out_ready) got_q.push_back({b_out_sat, b_out_data});

  function automatic logic [N*DW-1:0] uni(input int v);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = v[DW-1:0];
    return r;
  endfunction

  function automatic logic [N*DW-1:0] e0(input int v);
    logic [N*DW-1:0] r;
    r = '0;
    r[DW-1:0] = v[DW-1:0];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic run1(input string tag, input logic [N*DW-1:0] d, input logic [N*WW-1:0] w,
                      input logic relu, input int ed, input int es);
    a_in_data = d; a_in_weight = w; a_relu_en = relu; a_in_valid = 1'b1;
    tick;
    a_in_valid = 1'b0;
    chk({tag, "_early"}, a_out_valid, 0);
    tick;
    chk({tag, "_valid"}, a_out_valid, 1);
    chk({tag, "_data"}, $signed(a_out_data), ed);
    chk({tag, "_sat"}, a_out_sat, es);
    tick;
  endtask

  // Holds the beat until the DUT takes it; in_ready is sampled mid-cycle.
  task automatic put4(input logic [N*DW-1:0] d, input logic [N*WW-1:0] w, input logic relu);
    bit ok = 1'b0;
    int n = 0;
    b_in_data = d; b_in_weight = w; b_relu_en = relu; b_in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = b_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_res(input int n, input string tag);
    int t = 0;
    while (got_q.size() < n && t < 100) begin tick; t++; end
    chk({tag, "_count"}, got_q.size(), n);
  endtask

  task automatic pop_chk(input string tag, input int ed, input int es);
    logic [OW:0] r;
    if (got_q.size() == 0) begin
      chk({tag, "_missing"}, 0, 1);
      return;
    end
    r = got_q.pop_front();
    chk({tag, "_data"}, $signed(r[OW-1:0]), ed);
    chk({tag, "_sat"}, r[OW], es);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*DW-1:0] gd[3][4];
    logic [N*WW-1:0] gw[3][4];
    int gexp[3][2];
    int t;
    gd[0][0] = e0(100);  gw[0][0] = e0(10);   // 1000
    gd[0][1] = e0(100);  gw[0][1] = e0(20);   // 2000
    gd[0][2] = e0(-50);  gw[0][2] = e0(10);   // -500
    gd[0][3] = e0(40);   gw[0][3] = e0(40);   // 1600 -> 4100 -> 16
    for (int j = 0; j < 4; j++) begin gd[1][j] = e0(127); gw[1][j] = e0(127); end  // 64516 -> 252 -> 127 sat
    gd[2][0] = e0(-60);  gw[2][0] = e0(50);   // -3000
    gd[2][1] = e0(100);  gw[2][1] = e0(5);    // 500
    gd[2][2] = e0(0);    gw[2][2] = e0(0);
    gd[2][3] = e0(30);   gw[2][3] = e0(10);   // 300 -> -2200 -> -9
    gexp[0][0] = 16;   gexp[0][1] = 0;
    gexp[1][0] = 127;  gexp[1][1] = 1;
    gexp[2][0] = -9;   gexp[2][1] = 0;

    tick; tick;
    chk("rst_in_ready_a", a_in_ready, 0);
    chk("rst_in_ready_b", b_in_ready, 0);
    chk("rst_out_valid_a", a_out_valid, 0);
    chk("rst_out_data_a", $signed(a_out_data), 0);
    chk("rst_out_sat_a", a_out_sat, 0);
    chk("rst_busy_a", a_busy, 0);
    chk("rst_out_valid_b", b_out_valid, 0);
    chk("rst_busy_b", b_busy, 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", a_in_ready, 1);
    tick;

    // CIN=1: saturation, floor rounding, ReLU
    run1("sat_pos", uni(64), uni(64), 1'b0, 127, 1);
    run1("floor_neg", e0(-30), e0(10), 1'b0, -2, 0);
    run1("relu_neg", e0(-30), e0(10), 1'b1, 0, 0);
    run1("sat_neg", uni(-128), uni(127), 1'b0, -128, 1);
    chk("idle_busy_a", a_busy, 0);

    // CIN=1 back-to-back: a new result loads on the same edge the old one drains
    a_relu_en = 1'b0; a_in_valid = 1'b1;
    a_in_data = uni(64); a_in_weight = uni(64);
    tick;
    a_in_data = e0(-30); a_in_weight = e0(10);
    tick;
    chk("b2b_1_valid", a_out_valid, 1);
    chk("b2b_1_data", $signed(a_out_data), 127);
    a_in_data = e0(100); a_in_weight = e0(100);
    tick;
    a_in_valid = 1'b0;
    chk("b2b_2_valid", a_out_valid, 1);
    chk("b2b_2_data", $signed(a_out_data), -2);
    tick;
    chk("b2b_3_valid", a_out_valid, 1);
    chk("b2b_3_data", $signed(a_out_data), 39);
    chk("b2b_3_sat", a_out_sat, 0);
    tick;
    chk("b2b_done", a_out_valid, 0);

    // CIN=4: one group, exactly one result
    for (int j = 0; j < 4; j++) put4(gd[0][j], gw[0][j], 1'b0);
    b_in_valid = 1'b0;
    wait_res(1, "g1");
    repeat (4) tick;
    chk("g1_pulses", got_q.size(), 1);
    pop_chk("g1", 16, 0);
    chk("g1_idle_busy", b_busy, 0);

    // relu_en sampled only on the first beat of a group
    put4(e0(-100), e0(10), 1'b0);
    put4(e0(0), e0(0), 1'b1);
    put4(e0(0), e0(0), 1'b1);
    put4(e0(-100), e0(10), 1'b1);
    put4(e0(-100), e0(10), 1'b1);
    put4(e0(0), e0(0), 1'b0);
    put4(e0(0), e0(0), 1'b0);
    put4(e0(-100), e0(10), 1'b0);
    b_in_valid = 1'b0;
    wait_res(2, "relu_toggle");
    pop_chk("relu_off_grp", -8, 0);
    pop_chk("relu_on_grp", 0, 0);

    // Backpressure across three back-to-back groups
    b_out_ready = 1'b0;
    fork
      begin
        for (int g = 0; g < 3; g++)
          for (int j = 0; j < 4; j++) put4(gd[g][j], gw[g][j], 1'b0);
        b_in_valid = 1'b0;
      end
      begin
        t = 0;
        while (!b_out_valid && t < 200) begin tick; t++; end
        chk("bp_valid", b_out_valid, 1);
        chk("bp_in_ready", b_in_ready, 0);
        chk("bp_data", $signed(b_out_data), 16);
        repeat (3) tick;
        chk("bp_hold_valid", b_out_valid, 1);
        chk("bp_hold_data", $signed(b_out_data), 16);
        chk("bp_hold_busy", b_busy, 1);
        chk("bp_hold_in_ready", b_in_ready, 0);
        b_out_ready = 1'b1;
      end
    join
    wait_res(3, "bp");
    repeat (6) tick;
    chk("bp_no_dup", got_q.size(), 3);
    for (int g = 0; g < 3; g++) pop_chk($sformatf("bp_g%0d", g), gexp[g][0], gexp[g][1]);

    // Reset mid-group discards the partial sum
    put4(gd[0][0], gw[0][0], 1'b0);
    put4(gd[0][1], gw[0][1], 1'b0);
    b_in_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    chk("midrst_busy", b_busy, 0);
    chk("midrst_out_valid", b_out_valid, 0);
    rst = 1'b0;
    tick;
    for (int j = 0; j < 4; j++) put4(gd[0][j], gw[0][j], 1'b0);
    b_in_valid = 1'b0;
    wait_res(1, "midrst");
    repeat (4) tick;
    chk("midrst_pulses", got_q.size(), 1);
    pop_chk("midrst", 16, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
